// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fpdiv request front-end.
// Defines the FSM encoding, request/response structs and the cycle saturator.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_CAPTURE,
        S_HOLD
    } fpdiv_issue_state_t;

    localparam logic [63:0] FPDIV_QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [2:0]  rm;
        logic        op_type;
        logic        P;
        logic        OvEn;
        logic        UnEn;
    } fpdiv_req_t;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        denorm;
    } fpdiv_rsp_t;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/fpdiv_issue_if.sv
// Request, divider and response signals of the fpdiv issue block.
// The slave modport is the issue block; master is its environment.
interface fpdiv_issue_if #(
    parameter int TAGW = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [63:0]     req_op1;
    logic [63:0]     req_op2;
    logic [2:0]      req_rm;
    logic            req_op_type;
    logic            req_P;
    logic            req_OvEn;
    logic            req_UnEn;
    logic [TAGW-1:0] req_tag;

    logic [63:0]     div_op1;
    logic [63:0]     div_op2;
    logic [2:0]      div_rm;
    logic            div_op_type;
    logic            div_P;
    logic            div_OvEn;
    logic            div_UnEn;
    logic            div_start;
    logic            div_reset;
    logic            div_done;
    logic [63:0]     div_result;
    logic [4:0]      div_flags;
    logic            div_denorm;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [63:0]     rsp_result;
    logic [4:0]      rsp_flags;
    logic            rsp_denorm;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_timeout;
    logic [7:0]      rsp_cycles;

    modport slave (
        input  req_valid, req_op1, req_op2, req_rm, req_op_type, req_P,
               req_OvEn, req_UnEn, req_tag,
        output req_ready,
        output div_op1, div_op2, div_rm, div_op_type, div_P, div_OvEn,
               div_UnEn, div_start, div_reset,
        input  div_done, div_result, div_flags, div_denorm,
        output rsp_valid, rsp_result, rsp_flags, rsp_denorm, rsp_tag,
               rsp_timeout, rsp_cycles,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op1, req_op2, req_rm, req_op_type, req_P,
               req_OvEn, req_UnEn, req_tag,
        input  req_ready,
        input  div_op1, div_op2, div_rm, div_op_type, div_P, div_OvEn,
               div_UnEn, div_start, div_reset,
        output div_done, div_result, div_flags, div_denorm,
        input  rsp_valid, rsp_result, rsp_flags, rsp_denorm, rsp_tag,
               rsp_timeout, rsp_cycles,
        output rsp_ready
    );

endinterface

// File: rtl/fpdiv_timer.sv
// BUSY-cycle counter for one divider operation: cleared in START, counts in BUSY.
// Flags the last allowed BUSY cycle and reports the count saturated to 8 bits.
module fpdiv_timer
    import fpdiv_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic       o_term,
    output logic [7:0] o_cycles
);

    // One extra count of headroom: done may arrive in the terminal cycle.
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_term   = (r_cnt == CW'(TIMEOUT - 1));
    assign o_cycles = sat8(32'(r_cnt));

endmodule

// File: rtl/fpdiv_issue.sv
// Single-outstanding request front-end for the iterative fpdiv unit: launches,
// times out or flushes the divider and returns the result with its tag.
module fpdiv_issue
    import fpdiv_pkg::*;
#(
    parameter int TAGW    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    fpdiv_issue_if.slave  bus
);

    localparam logic [7:0] TIMEOUT_CYCLES = sat8(TIMEOUT);

    fpdiv_issue_state_t r_state, w_next;

    fpdiv_req_t      r_req;
    logic [TAGW-1:0] r_tag;
    fpdiv_rsp_t      r_rsp;
    logic            r_rsp_timeout;
    logic [7:0]      r_rsp_cycles;
    logic            r_rsp_valid;
    logic            r_div_start;
    logic            r_div_reset;

    logic            w_req_ready;
    logic            w_accept;
    logic            w_capture;
    logic            w_timeout;
    logic            w_abort;
    logic            w_term;
    logic [7:0]      w_cycles;

    fpdiv_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state == S_START),
        .i_inc    (r_state == S_BUSY),
        .o_term   (w_term),
        .o_cycles (w_cycles)
    );

    // Gated by reset so the consumer never sees ready while the block is held.
    assign w_req_ready = (r_state == S_IDLE) && !flush && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_abort   = 1'b0;
        if (flush) begin
            w_next  = S_IDLE;
            w_abort = (r_state == S_START) || (r_state == S_BUSY) ||
                      (r_state == S_CAPTURE);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && w_req_ready) begin
                        w_accept = 1'b1;
                        w_next   = S_START;
                    end
                end
                S_START: w_next = S_BUSY;
                S_BUSY: begin
                    if (bus.div_done) begin
                        w_next = S_CAPTURE;
                    end else if (w_term) begin
                        w_timeout = 1'b1;
                        w_next    = S_HOLD;
                    end
                end
                S_CAPTURE: begin
                    w_capture = 1'b1;
                    w_next    = S_HOLD;
                end
                S_HOLD: begin
                    if (bus.rsp_ready) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_start <= 1'b0;
            r_div_reset <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_div_start <= w_accept;
            r_div_reset <= w_abort || w_timeout;
            r_rsp_valid <= (w_next == S_HOLD);
        end
    end

    // Operands stay on the divider inputs from one acceptance to the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req <= '0;
            r_tag <= '0;
        end else if (w_accept) begin
            r_req <= '{op1:     bus.req_op1,
                       op2:     bus.req_op2,
                       rm:      bus.req_rm,
                       op_type: bus.req_op_type,
                       P:       bus.req_P,
                       OvEn:    bus.req_OvEn,
                       UnEn:    bus.req_UnEn};
            r_tag <= bus.req_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp         <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_cycles  <= '0;
        end else if (w_capture) begin
            r_rsp         <= '{result: bus.div_result,
                               flags:  bus.div_flags,
                               denorm: bus.div_denorm};
            r_rsp_timeout <= 1'b0;
            r_rsp_cycles  <= w_cycles;
        end else if (w_timeout) begin
            r_rsp         <= '{result: FPDIV_QNAN, flags: 5'd0, denorm: 1'b0};
            r_rsp_timeout <= 1'b1;
            r_rsp_cycles  <= TIMEOUT_CYCLES;
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.div_op1     = r_req.op1;
    assign bus.div_op2     = r_req.op2;
    assign bus.div_rm      = r_req.rm;
    assign bus.div_op_type = r_req.op_type;
    assign bus.div_P       = r_req.P;
    assign bus.div_OvEn    = r_req.OvEn;
    assign bus.div_UnEn    = r_req.UnEn;
    assign bus.div_start   = r_div_start;
    assign bus.div_reset   = r_div_reset;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_result  = r_rsp.result;
    assign bus.rsp_flags   = r_rsp.flags;
    assign bus.rsp_denorm  = r_rsp.denorm;
    assign bus.rsp_tag     = r_tag;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.rsp_cycles  = r_rsp_cycles;

endmodule

// File: tb/tb_fpdiv_issue.sv
// Directed bench for fpdiv_issue: normal ops, timeout with stalled response,
// flush and late done, flush in IDLE, and asynchronous reset mid-operation.
module tb_fpdiv_issue;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    fpdiv_issue_if #(.TAGW(4)) bus ();

    fpdiv_issue #(
        .TAGW    (4),
        .TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    logic [63:0] last_op1 = 64'd0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive point: just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample point: falling edge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] op1, input logic [63:0] op2,
                        input logic op_type, input logic [3:0] tag);
        bus.req_valid   = 1'b1;
        bus.req_op1     = op1;
        bus.req_op2     = op2;
        bus.req_rm      = 3'd1;
        bus.req_op_type = op_type;
        bus.req_P       = 1'b0;
        bus.req_OvEn    = 1'b1;
        bus.req_UnEn    = 1'b0;
        bus.req_tag     = tag;
    endtask

    // Starts and ends just after a rising edge with the block in IDLE.
    task automatic run_op(input logic [63:0] op1, input logic [63:0] op2,
                          input logic op_type, input logic [3:0] tag, input int lat,
                          input logic [63:0] res, input logic [4:0] fl);
        int starts;
        send(op1, op2, op_type, tag);
        bus.rsp_ready = 1'b1;
        mid();
        check("idle_rsp_valid", bus.rsp_valid, 0);
        check("idle_req_ready", bus.req_ready, 1);
        check("idle_div_op1", bus.div_op1, last_op1);
        cyc();
        bus.req_valid = 1'b0;
        mid();
        check("start_pulse", bus.div_start, 1);
        check("start_op1", bus.div_op1, op1);
        check("start_op2", bus.div_op2, op2);
        check("start_op_type", bus.div_op_type, op_type);
        check("start_req_ready", bus.req_ready, 0);
        starts = 0;
        for (int b = 1; b <= lat; b++) begin
            cyc();
            if (b == lat) begin
                bus.div_done   = 1'b1;
                bus.div_result = res;
                bus.div_flags  = fl;
            end
            mid();
            starts += int'(bus.div_start);
        end
        check("start_once", starts, 0);
        cyc();
        bus.div_done = 1'b0;
        mid();
        check("capture_valid", bus.rsp_valid, 0);
        cyc();
        bus.div_result = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.div_flags  = 5'd0;
        mid();
        check("hold_valid", bus.rsp_valid, 1);
        check("hold_result", bus.rsp_result, res);
        check("hold_flags", bus.rsp_flags, fl);
        check("hold_tag", bus.rsp_tag, tag);
        check("hold_cycles", bus.rsp_cycles, lat);
        check("hold_timeout", bus.rsp_timeout, 0);
        check("hold_op1", bus.div_op1, op1);
        cyc();
        last_op1 = op1;
    endtask

    initial begin
        int          resets;
        int          bad;
        logic [63:0] hold_res;

        bus.req_valid   = 1'b0;
        bus.req_op1     = 64'd0;
        bus.req_op2     = 64'd0;
        bus.req_rm      = 3'd0;
        bus.req_op_type = 1'b0;
        bus.req_P       = 1'b0;
        bus.req_OvEn    = 1'b0;
        bus.req_UnEn    = 1'b0;
        bus.req_tag     = 4'd0;
        bus.div_done    = 1'b0;
        bus.div_result  = 64'd0;
        bus.div_flags   = 5'd0;
        bus.div_denorm  = 1'b0;
        bus.rsp_ready   = 1'b0;

        #22 reset = 1'b1;
        mid();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_div_start", bus.div_start, 0);
        check("rst_div_reset", bus.div_reset, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_rsp_cycles", bus.rsp_cycles, 0);
        cyc();

        // 3.0 / 2.0 = 1.5
        run_op(64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd3, 20,
               64'h3FF8_0000_0000_0000, 5'h00);
        // back-to-back sqrt: sqrt(4) = 2, sqrt(9) = 3
        run_op(64'h4010_0000_0000_0000, 64'd0, 1'b1, 4'd1, 5,
               64'h4000_0000_0000_0000, 5'h01);
        run_op(64'h4022_0000_0000_0000, 64'd0, 1'b1, 4'd2, 7,
               64'h4008_0000_0000_0000, 5'h00);

        // Divider never finishes: timeout after 64 BUSY cycles
        send(64'h3FF0_0000_0000_0000, 64'h0, 1'b0, 4'd7);
        cyc();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        mid();
        check("to_start", bus.div_start, 1);
        resets = 0;
        for (int b = 1; b <= 64; b++) begin
            cyc();
            mid();
            resets += int'(bus.div_reset);
            if (b == 64) check("to_busy64_valid", bus.rsp_valid, 0);
        end
        check("to_no_early_reset", resets, 0);
        cyc();
        send(64'h4014_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 4'd9);
        mid();
        check("to_div_reset", bus.div_reset, 1);
        check("to_valid", bus.rsp_valid, 1);
        check("to_result", bus.rsp_result, 64'h7FF8_0000_0000_0000);
        check("to_flags", bus.rsp_flags, 0);
        check("to_flag", bus.rsp_timeout, 1);
        check("to_cycles", bus.rsp_cycles, 64);
        check("to_tag", bus.rsp_tag, 7);
        check("to_req_ready", bus.req_ready, 0);
        hold_res = bus.rsp_result;
        bad = 0;
        for (int i = 2; i <= 10; i++) begin
            cyc();
            mid();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== hold_res ||
                bus.rsp_timeout !== 1'b1 || bus.req_ready !== 1'b0 ||
                bus.div_reset !== 1'b0 || bus.rsp_tag !== 4'd7) bad++;
        end
        check("hold_stable", bad, 0);
        cyc();
        bus.rsp_ready = 1'b1;
        mid();
        check("hs_req_ready", bus.req_ready, 0);
        check("hs_valid", bus.rsp_valid, 1);
        cyc();
        mid();
        check("post_hs_valid", bus.rsp_valid, 0);
        check("post_hs_req_ready", bus.req_ready, 1);
        check("post_hs_op1", bus.div_op1, 64'h3FF0_0000_0000_0000);
        cyc();
        bus.req_valid = 1'b0;
        mid();
        check("acc_after_hs", bus.div_start, 1);
        check("acc_after_hs_op1", bus.div_op1, 64'h4014_0000_0000_0000);

        // Flush in the 5th BUSY cycle, then a late done
        for (int b = 1; b <= 5; b++) begin
            cyc();
            if (b == 5) flush = 1'b1;
        end
        mid();
        check("flush_req_ready", bus.req_ready, 0);
        cyc();
        flush = 1'b0;
        bus.div_done = 1'b1;
        mid();
        check("flush_div_reset", bus.div_reset, 1);
        check("flush_idle", bus.req_ready, 1);
        cyc();
        bus.div_done = 1'b0;
        mid();
        check("flush_reset_once", bus.div_reset, 0);
        check("late_done_valid1", bus.rsp_valid, 0);
        cyc();
        mid();
        check("late_done_valid2", bus.rsp_valid, 0);
        check("late_done_req_ready", bus.req_ready, 1);

        // A request during flush in IDLE is refused
        cyc();
        flush = 1'b1;
        send(64'h4020_0000_0000_0000, 64'h0, 1'b0, 4'd4);
        mid();
        check("flush_idle_ready", bus.req_ready, 0);
        cyc();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        mid();
        check("flush_idle_no_start", bus.div_start, 0);
        check("flush_idle_op1", bus.div_op1, 64'h4014_0000_0000_0000);

        // Asynchronous reset in BUSY
        cyc();
        send(64'h4030_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd5);
        cyc();
        bus.req_valid = 1'b0;
        for (int b = 1; b <= 3; b++) cyc();
        #2 reset = 1'b0;
        #1;
        check("arst_req_ready", bus.req_ready, 0);
        check("arst_div_start", bus.div_start, 0);
        check("arst_div_reset", bus.div_reset, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_div_op1", bus.div_op1, 0);
        check("arst_rsp_result", bus.rsp_result, 0);
        check("arst_rsp_tag", bus.rsp_tag, 0);
        check("arst_rsp_timeout", bus.rsp_timeout, 0);
        check("arst_rsp_cycles", bus.rsp_cycles, 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        mid();
        check("arst_release_ready", bus.req_ready, 1);
        check("arst_release_valid", bus.rsp_valid, 0);
        cyc();
        mid();
        check("arst_no_start", bus.div_start, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpdiv_issue.md
# fpdiv_issue

Request front-end for the iterative FP divide/square-root unit `fpdiv`.
- Accepts one operation at a time over a valid/ready handshake and holds its operands stable on the divider inputs.
- Launches the divider with a one-cycle `start` pulse and captures result, flags and denorm the cycle after `done`.
- Returns them with the request tag over a valid/ready response handshake.
- Provides flush, timeout abort and a per-operation latency count.

## Interface
Parameters:
- TAGW, 4, width of request/response tag
- TIMEOUT, 64, maximum BUSY cycles before abort (≥2)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low (asserted when 0); name kept as in the codebase
- flush  in  1  synchronous abort of any in-flight operation
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op1, req_op2  in  64  operands A, B
- req_rm  in  3  rounding mode
- req_op_type  in  1  0 divide, 1 sqrt
- req_P  in  1  0 double, 1 single
- req_OvEn, req_UnEn  in  1  trap enables
- req_tag  in  TAGW  opaque tag
- div_op1, div_op2  out  64  latched operands to divider
- div_rm, div_op_type, div_P, div_OvEn, div_UnEn  out  3/1/1/1/1  latched controls to divider
- div_start  out  1  one-cycle launch pulse
- div_reset  out  1  one-cycle active-high divider reset (abort)
- div_done  in  1  divider done pulse
- div_result  in  64  divider AS_Result
- div_flags  in  5  divider Flags
- div_denorm  in  1  divider Denorm
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  64  captured result
- rsp_flags  out  5  captured flags
- rsp_denorm  out  1  captured denorm
- rsp_tag  out  TAGW  tag of the request
- rsp_timeout  out  1  1 = aborted by timeout
- rsp_cycles  out  8  BUSY cycles of this operation, saturating at 255

## Operation
- States: IDLE, START, BUSY, CAPTURE, HOLD. One operation outstanding at most.
- IDLE:
  - req_ready = 1 when flush = 0.
  - On req_valid & req_ready, latch all req_* fields into the div_* and tag registers, then go to START.
- START: div_start = 1 for exactly this cycle. Clear the cycle counter. Go to BUSY.
- BUSY: the counter increments every cycle.
  - div_done = 1 → CAPTURE.
  - Otherwise, when the counter reaches TIMEOUT-1: pulse div_reset, load rsp_result = 64'h7FF8_0000_0000_0000, rsp_flags = 0, rsp_denorm = 0, rsp_timeout = 1, then go to HOLD.
- CAPTURE: register div_result, div_flags, div_denorm; rsp_timeout = 0; rsp_cycles = the counter value (saturated). Go to HOLD.
- HOLD: rsp_valid = 1 and all rsp_* held stable until rsp_valid & rsp_ready, then go to IDLE. No request is accepted in the handshake cycle.
- div_* operand outputs hold their value from acceptance until the next acceptance; they do not change during START, BUSY or CAPTURE.
- flush has the highest priority in every state:
  - Next state is IDLE and rsp_valid drops.
  - div_reset pulses one cycle if the state was START, BUSY or CAPTURE.
  - A req_valid in the flush cycle is not accepted.
- div_done outside BUSY is ignored.
- div_done and timeout in the same cycle: div_done wins.

## Timing
- Reset (asynchronous) values:
  - state = IDLE; req_ready = 1 once flush = 0.
  - div_start, div_reset, rsp_valid, rsp_timeout = 0.
  - All data registers and rsp_cycles = 0.
- Accept at edge E0 → div_start high in cycle E0+1 → first BUSY cycle E0+2.
- div_done sampled high in cycle N → capture at end of N+1 (the divider's output registers update on N's edge) → rsp_valid high from N+2.
- Minimum request-to-response latency is 4 cycles plus the divider latency.
- Reset asserted mid-operation returns to IDLE immediately. div_reset is not driven; the divider shares the system reset.

## Structure
- Package `fpdiv_pkg`:
  - state enum `fpdiv_issue_state_t`
  - constant `FPDIV_QNAN = 64'h7FF8_0000_0000_0000`
  - packed structs `fpdiv_req_t` (operands, rm, op_type, P, OvEn, UnEn) and `fpdiv_rsp_t` (result, flags, denorm)
- One sub-module, `fpdiv_timer`: counter that clears on START, increments in BUSY, and outputs a terminal flag at TIMEOUT-1 plus an 8-bit saturated value.

## Test plan
- Divide 0x4008_0000_0000_0000 / 0x4000_0000_0000_0000, tag 3, model done after 20 cycles, rsp_ready = 1 → single div_start pulse, rsp_result 0x3FF8_0000_0000_0000, rsp_tag 3, rsp_cycles 20, rsp_timeout 0.
- Model never asserts done, TIMEOUT = 64 → div_reset pulses once after 64 BUSY cycles, rsp_result 0x7FF8_0000_0000_0000, rsp_timeout 1.
- rsp_ready held 0 for 10 cycles in HOLD with req_valid = 1 → rsp_* stable, req_ready = 0 throughout, accept occurs only in the cycle after the response handshake.
- flush in the 5th BUSY cycle → IDLE next cycle, one div_reset pulse, no response; a late div_done is ignored.
- Back-to-back sqrt requests (tags 1, 2) → responses in order, div_op1 changes only on acceptance.
- reset driven low during BUSY → all outputs 0 asynchronously, req_ready = 1 after release.
